sequenciador_display: RTL and testbench

SEQUENCIADOR_DISPLAY -- requirements
Module: sequenciador_display

---
 rtl/sequenciador_display_pkg.sv | 31 +++
 rtl/rom_init_oled.sv | 40 ++++
 rtl/sequenciador_display.sv | 162 ++++++++++++++++
 tb/tb_sequenciador_display.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_display_pkg.sv
// Shared definitions for the OLED frame sequencer: FSM encoding, address-window commands, frame size, defaults.
// Pure definitions package, no timing or flow-control behaviour of its own.
package sequenciador_display_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_FETCH,
        ST_STREAM
    } state_t;

    localparam int          FRAME_BYTES        = 1024;
    localparam int          ADDR_CMDS          = 6;
    localparam logic [23:0] DEF_REFRESH_CYCLES = 24'd5_000_000;
    localparam int          DEF_INIT_LEN       = 25;

    // Column window 0..127, page window 0..7: the whole 128x64 panel.
    function automatic logic [7:0] addr_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h21;
            3'd1:    return 8'h00;
            3'd2:    return 8'h7F;
            3'd3:    return 8'h22;
            3'd4:    return 8'h00;
            3'd5:    return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rom_init_oled.sv
// SSD1306 power-up command ROM; combinational read, no latency.
// No flow control: the sequencer owns the index and only advances it on an accepted byte.
module rom_init_oled (
    input  logic [4:0] idx_i,
    output logic [7:0] data_o
);

    always_comb begin
        data_o = 8'hE3;
        case (idx_i)
            5'd0:  data_o = 8'hAE;
            5'd1:  data_o = 8'hD5;
            5'd2:  data_o = 8'h80;
            5'd3:  data_o = 8'hA8;
            5'd4:  data_o = 8'h3F;
            5'd5:  data_o = 8'hD3;
            5'd6:  data_o = 8'h00;
            5'd7:  data_o = 8'h40;
            5'd8:  data_o = 8'h8D;
            5'd9:  data_o = 8'h14;
            5'd10: data_o = 8'h20;
            5'd11: data_o = 8'h00;
            5'd12: data_o = 8'hA1;
            5'd13: data_o = 8'hC8;
            5'd14: data_o = 8'hDA;
            5'd15: data_o = 8'h12;
            5'd16: data_o = 8'h81;
            5'd17: data_o = 8'hCF;
            5'd18: data_o = 8'hD9;
            5'd19: data_o = 8'hF1;
            5'd20: data_o = 8'hDB;
            5'd21: data_o = 8'h40;
            5'd22: data_o = 8'hA4;
            5'd23: data_o = 8'hA6;
            5'd24: data_o = 8'hAF;
            default: data_o = 8'hE3;
        endcase
    end

endmodule

// File: rtl/sequenciador_display.sv
// Sequences OLED init, address window and 1024 image bytes to a serial transmitter; one byte per 2 cycles at best.
// Registered valid/ready output: byte, D/C flag and img_addr hold while tx_ready is low.
module sequenciador_display
    import sequenciador_display_pkg::*;
#(
    parameter logic [23:0] REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int          INIT_LEN       = DEF_INIT_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] estado,
    output logic [9:0] img_addr,
    input  logic [7:0] img_data,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [4:0]  INIT_LAST    = 5'(INIT_LEN - 1);
    localparam logic [2:0]  CMD_LAST     = 3'(ADDR_CMDS - 1);
    localparam logic [9:0]  PIX_LAST     = 10'(FRAME_BYTES - 1);
    localparam logic [23:0] REFRESH_LAST = REFRESH_CYCLES - 24'd1;

    state_t      state_q, state_d;
    logic [4:0]  init_idx_q, init_idx_d;
    logic [2:0]  addr_idx_q, addr_idx_d;
    logic [9:0]  img_addr_q, img_addr_d;
    logic [23:0] refresh_q, refresh_d;
    logic [3:0]  estado_q, estado_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_dc_q, tx_dc_d;
    logic        tx_valid_q, tx_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  rom_byte;
    logic        accept;

    rom_init_oled u_rom (
        .idx_i  (init_idx_q),
        .data_o (rom_byte)
    );

    assign accept = tx_valid_q & tx_ready;

    // Each byte is loaded into the output register when valid is low and dropped on acceptance,
    // so a stalled byte simply sits in the register untouched.
    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        addr_idx_d   = addr_idx_q;
        img_addr_d   = img_addr_q;
        refresh_d    = 24'd0;
        estado_d     = estado_q;
        tx_data_d    = tx_data_q;
        tx_dc_d      = tx_dc_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (!tx_valid_q) begin
                    tx_data_d  = rom_byte;
                    tx_dc_d    = 1'b0;
                    tx_valid_d = 1'b1;
                end else if (accept) begin
                    tx_valid_d = 1'b0;
                    if (init_idx_q == INIT_LAST) begin
                        init_idx_d = 5'd0;
                        estado_d   = estado;
                        state_d    = ST_ADDR;
                    end else begin
                        init_idx_d = init_idx_q + 5'd1;
                    end
                end
            end
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if ((estado != estado_q) || (refresh_q == REFRESH_LAST)) begin
                    estado_d = estado;
                    state_d  = ST_ADDR;
                end else begin
                    refresh_d = refresh_q + 24'd1;
                end
            end
            ST_ADDR: begin
                if (!tx_valid_q) begin
                    tx_data_d  = addr_cmd(addr_idx_q);
                    tx_dc_d    = 1'b0;
                    tx_valid_d = 1'b1;
                end else if (accept) begin
                    tx_valid_d = 1'b0;
                    if (addr_idx_q == CMD_LAST) begin
                        addr_idx_d = 3'd0;
                        img_addr_d = 10'd0;
                        state_d    = ST_FETCH;
                    end else begin
                        addr_idx_d = addr_idx_q + 3'd1;
                    end
                end
            end
            ST_FETCH: begin
                // img_data for the current img_addr has settled by the end of this cycle.
                tx_data_d  = img_data;
                tx_dc_d    = 1'b1;
                tx_valid_d = 1'b1;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    if (img_addr_q == PIX_LAST) begin
                        img_addr_d   = 10'd0;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        img_addr_d = img_addr_q + 10'd1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_idx_q   <= 5'd0;
            addr_idx_q   <= 3'd0;
            img_addr_q   <= 10'd0;
            refresh_q    <= 24'd0;
            estado_q     <= 4'd0;
            tx_data_q    <= 8'h00;
            tx_dc_q      <= 1'b0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            addr_idx_q   <= addr_idx_d;
            img_addr_q   <= img_addr_d;
            refresh_q    <= refresh_d;
            estado_q     <= estado_d;
            tx_data_q    <= tx_data_d;
            tx_dc_q      <= tx_dc_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign img_addr   = img_addr_q;
    assign tx_data    = tx_data_q;
    assign tx_dc      = tx_dc_q;
    assign tx_valid   = tx_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sequenciador_display.sv
// Scoreboard bench for sequenciador_display: expected bytes are queued by the stimulus and
// popped by a monitor on every accepted handshake.
module tb_sequenciador_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] estado;
    logic [9:0] img_addr;
    logic [7:0] img_data;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;

    logic [3:0] img_sel;
    logic       rand_ready;
    int         chk_cnt  = 0;
    int         pass_cnt = 0;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic [9:0] addr;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] init_tab [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                  8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                  8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] win_tab [6]   = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    always #5 clk = ~clk;

    // Image controller model: a distinct byte per address and image selection.
    function automatic logic [7:0] img_fn(input logic [3:0] sel, input logic [9:0] a);
        return a[7:0] ^ {sel, 2'b00, a[9:8]};
    endfunction

    assign img_data = img_fn(img_sel, img_addr);

    sequenciador_display #(
        .REFRESH_CYCLES (24'd100),
        .INIT_LEN       (25)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .estado     (estado),
        .img_addr   (img_addr),
        .img_data   (img_data),
        .tx_data    (tx_data),
        .tx_dc      (tx_dc),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_init();
        for (int i = 0; i < 25; i++) exp_q.push_back('{dc: 1'b0, data: init_tab[i], addr: 10'd0});
    endtask

    task automatic push_frame(input logic [3:0] sel);
        for (int i = 0; i < 6; i++) exp_q.push_back('{dc: 1'b0, data: win_tab[i], addr: 10'd0});
        for (int a = 0; a < 1024; a++)
            exp_q.push_back('{dc: 1'b1, data: img_fn(sel, 10'(a)), addr: 10'(a)});
    endtask

    task automatic wait_fd(input int budget, input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frame_done !== 1'b1) begin
            chk_cnt++;
            $display("FAIL %s: frame_done not seen within %0d cycles, expected a pulse", name, budget);
        end
    endtask

    task automatic wait_addr(input logic [9:0] target, input int budget, input string name);
        int n = 0;
        while (!(img_addr == target && tx_valid === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(img_addr == target && tx_valid === 1'b1)) begin
            chk_cnt++;
            $display("FAIL %s: img_addr %0d never streamed, last img_addr=%0d", name, target, img_addr);
        end
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on handshake, stall stability, frame_done pulse.
    initial begin
        exp_t        e;
        logic        stall_prev = 1'b0;
        logic        fd_exp     = 1'b0;
        logic        fd_next;
        logic [18:0] stall_val  = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
                fd_exp     = 1'b0;
            end else begin
                if (fd_exp || frame_done) check("frame_done", 32'(frame_done), 32'(fd_exp));
                if (stall_prev) begin
                    check("stall_valid", 32'(tx_valid), 32'd1);
                    check("stall_hold", 32'({tx_dc, tx_data, img_addr}), 32'(stall_val));
                end
                fd_next = 1'b0;
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_byte: got dc=%0d data=0x%0h, expected none", tx_dc, tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'({tx_dc, tx_data, img_addr}), 32'(e));
                        fd_next = e.dc && (e.addr == 10'd1023);
                    end
                end
                fd_exp     = fd_next;
                stall_prev = tx_valid && !tx_ready;
                stall_val  = {tx_dc, tx_data, img_addr};
            end
        end
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        estado     = 4'b0010;
        img_sel    = 4'b0010;
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_dc", 32'(tx_dc), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_img_addr", 32'(img_addr), 32'd0);
        check("rst_estado_lat", 32'(dut.estado_q), 32'd0);

        // Init sequence then first frame, ready always high.
        push_init();
        push_frame(4'b0010);
        rst_n = 1'b1;
        wait_fd(5000, "first_frame");
        check("first_busy_fall", 32'(busy), 32'd0);
        check("first_drained", 32'(exp_q.size()), 32'd0);

        // Periodic refresh with constant estado.
        push_frame(4'b0010);
        n = 0;
        while (busy !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("refresh_gap", 32'(n), 32'd100);

        // Refresh frame streamed against a randomly stalling transmitter.
        rand_ready = 1'b1;
        wait_fd(20000, "stall_frame");
        rand_ready = 1'b0;
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // estado change while idle.
        repeat (5) @(negedge clk);
        estado  = 4'b0101;
        img_sel = 4'b0101;
        push_frame(4'b0101);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("estado_start_within_2", 32'(n <= 2), 32'd1);
        check("estado_latched_5", 32'(dut.estado_q), 32'h5);

        // estado change mid-stream: frame finishes, next one follows at once.
        wait_addr(10'd300, 5000, "reach_300");
        estado = 4'b0110;
        wait_fd(5000, "midstream_frame");
        check("midstream_drained", 32'(exp_q.size()), 32'd0);
        img_sel = 4'b0110;
        push_frame(4'b0110);
        @(negedge clk);
        check("back_to_back_busy", 32'(busy), 32'd1);
        check("estado_latched_6", 32'(dut.estado_q), 32'h6);

        // Asynchronous reset in the middle of a frame.
        wait_addr(10'd500, 5000, "reach_500");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'h00);
        check("arst_tx_dc", 32'(tx_dc), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_img_addr", 32'(img_addr), 32'd0);
        check("arst_estado_lat", 32'(dut.estado_q), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        push_frame(4'b0110);
        rst_n = 1'b1;
        wait_fd(5000, "post_reset_frame");
        check("post_reset_drained", 32'(exp_q.size()), 32'd0);
        check("post_reset_busy_fall", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
